// File: rtl/tft_fillmod_pkg.sv
// ============================================================================
// tft_fillmod_pkg : call encodings, request bit positions and FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package tft_fillmod_pkg;

  localparam logic [2:0] CALL_NONE = 3'b000;
  localparam logic [2:0] CALL_INIT = 3'b100;
  localparam logic [2:0] CALL_WIN  = 3'b010;
  localparam logic [2:0] CALL_PIX  = 3'b001;

  localparam int REQ_INIT = 1;
  localparam int REQ_FILL = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_WIN  = 3'd2,
    ST_PIX  = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tft_fillmod.sv
// ============================================================================
// tft_fillmod : expands init / rectangle-fill requests into base-module calls
// Rev 1.0
// ============================================================================
`default_nettype none

module tft_fillmod
  import tft_fillmod_pkg::*;
#(
  parameter int CW    = 8,
  parameter int PIX_W = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [1:0]        iCall,
  output logic              oDone,
  input  logic [4*CW-1:0]   iArea,
  input  logic [PIX_W-1:0]  iColor,
  output logic              oBusy,
  output logic [2:0]        oCall,
  input  logic              iDone,
  output logic [4*CW-1:0]   oData
);

  state_t             state_q;
  logic [2:0]         call_q;
  logic [4*CW-1:0]    data_q;
  logic               done_q;
  logic               busy_q;
  logic [4*CW-1:0]    area_q;
  logic [PIX_W-1:0]   color_q;
  logic [CW:0]        x_q;
  logic [CW:0]        y_q;

  logic [CW-1:0] in_x0, in_y0, in_x1, in_y1;
  logic [CW-1:0] x0, x1, y1;
  logic          in_valid;
  logic          last_col;
  logic          last_row;

  assign in_x0    = iArea[4*CW-1:3*CW];
  assign in_y0    = iArea[3*CW-1:2*CW];
  assign in_x1    = iArea[2*CW-1:CW];
  assign in_y1    = iArea[CW-1:0];
  assign in_valid = (in_x1 >= in_x0) && (in_y1 >= in_y0);

  assign x0       = area_q[4*CW-1:3*CW];
  assign x1       = area_q[2*CW-1:CW];
  assign y1       = area_q[CW-1:0];
  assign last_col = (x_q == {1'b0, x1});
  assign last_row = (y_q == {1'b0, y1});

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      call_q  <= CALL_NONE;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      area_q  <= '0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((iCall != 2'b00) && !done_q) begin
            area_q  <= iArea;
            color_q <= iColor;
            x_q     <= {1'b0, in_x0};
            y_q     <= {1'b0, in_y0};
            if (iCall[REQ_INIT]) begin
              state_q <= ST_INIT;
              busy_q  <= 1'b1;
            end else if (iCall[REQ_FILL] && in_valid) begin
              state_q <= ST_WIN;
              busy_q  <= 1'b1;
            end else begin
              // Empty rectangle: finish without touching the base module
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        ST_INIT: begin
          if (call_q == CALL_NONE) begin
            call_q <= CALL_INIT;
            data_q <= '0;
          end else if (iDone) begin
            call_q  <= CALL_NONE;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        ST_WIN: begin
          if (call_q == CALL_NONE) begin
            call_q <= CALL_WIN;
            data_q <= area_q;
          end else if (iDone) begin
            call_q  <= CALL_NONE;
            state_q <= ST_GAP;
          end
        end

        // One idle cycle, then the next pixel call is launched on exit
        ST_GAP: begin
          call_q  <= CALL_PIX;
          data_q  <= {{(4*CW-PIX_W){1'b0}}, color_q};
          state_q <= ST_PIX;
        end

        ST_PIX: begin
          if ((call_q != CALL_NONE) && iDone) begin
            call_q <= CALL_NONE;
            if (last_col && last_row) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (last_col) begin
              x_q     <= {1'b0, x0};
              y_q     <= y_q + 1'b1;
              state_q <= ST_GAP;
            end else begin
              x_q     <= x_q + 1'b1;
              state_q <= ST_GAP;
            end
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          call_q  <= CALL_NONE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oCall = call_q;
  assign oData = data_q;
  assign oDone = done_q;
  assign oBusy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_tft_fillmod.sv
// ============================================================================
// tb_tft_fillmod : table + random requests against a call-list reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tft_fillmod;

  localparam logic [2:0] C_INIT = 3'b100;
  localparam logic [2:0] C_WIN  = 3'b010;
  localparam logic [2:0] C_PIX  = 3'b001;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic [1:0]  iCall = 2'b00;
  logic        oDone;
  logic [31:0] iArea = '0;
  logic [15:0] iColor = '0;
  logic        oBusy;
  logic [2:0]  oCall;
  logic        iDone = 1'b0;
  logic [31:0] oData;

  tft_fillmod #(.CW(8), .PIX_W(16)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .iCall (iCall),
    .oDone (oDone),
    .iArea (iArea),
    .iColor(iColor),
    .oBusy (oBusy),
    .oCall (oCall),
    .iDone (iDone),
    .oData (oData)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Base module: iDone pulses on the third sampled cycle of a held call
  int bm_cnt = 0;
  always @(negedge CLOCK) begin
    if (!RESET || oCall == 3'b000) begin
      bm_cnt = 0;
      iDone  = 1'b0;
    end else begin
      bm_cnt++;
      iDone = (bm_cnt == 3);
    end
  end

  // Monitor: record each call as it starts, check holding behaviour
  logic [2:0]  cap_call[$];
  logic [31:0] cap_data[$];
  int          done_cnt = 0;
  logic [2:0]  prev_call = '0;
  logic [31:0] prev_data = '0;

  always @(negedge CLOCK) begin
    if (RESET) begin
      if (oCall != 3'b000 && prev_call == 3'b000) begin
        cap_call.push_back(oCall);
        cap_data.push_back(oData);
      end
      if (oCall != 3'b000 && prev_call != 3'b000) begin
        chk("call_held", oCall, prev_call);
        chk("data_stable", oData, prev_data);
      end
      if (oDone) begin
        done_cnt++;
        chk("busy_low_at_done", oBusy, 0);
      end
    end
    prev_call = oCall;
    prev_data = oData;
  end

  // Reference: the ordered list of calls a request must produce
  logic [2:0]  exp_call[$];
  logic [31:0] exp_data[$];

  task automatic build_exp(input logic [1:0] c, input logic [31:0] a, input logic [15:0] col);
    int x0, y0, x1, y1, npix;
    exp_call.delete();
    exp_data.delete();
    x0 = int'(a[31:24]); y0 = int'(a[23:16]); x1 = int'(a[15:8]); y1 = int'(a[7:0]);
    if (c[1]) begin
      exp_call.push_back(C_INIT);
      exp_data.push_back(32'd0);
    end else if (c[0] && x1 >= x0 && y1 >= y0) begin
      exp_call.push_back(C_WIN);
      exp_data.push_back(a);
      npix = (x1 - x0 + 1) * (y1 - y0 + 1);
      for (int n = 0; n < npix; n++) begin
        exp_call.push_back(C_PIX);
        exp_data.push_back({16'd0, col});
      end
    end
  endtask

  task automatic run_req(input logic [1:0] c, input logic [31:0] a, input logic [15:0] col,
                         output int lat, output int n_i, output int n_w, output int n_p);
    int m;
    @(negedge CLOCK);
    cap_call.delete();
    cap_data.delete();
    done_cnt = 0;
    build_exp(c, a, col);
    iCall = c; iArea = a; iColor = col;
    lat = 0;
    do begin
      @(negedge CLOCK);
      lat++;
      if (lat == 1 && exp_call.size() != 0) chk("busy_after_accept", oBusy, 1);
      if (lat == 4) begin
        iColor = 16'($urandom);
        iArea  = $urandom;
      end
    end while (!oDone && lat < 5000);
    if (!oDone) chk("done_timeout", oDone, 1);
    iCall = 2'b00;
    repeat (3) @(negedge CLOCK);
    chk("done_pulses", done_cnt, 1);
    chk("num_calls", cap_call.size(), exp_call.size());
    m = (cap_call.size() < exp_call.size()) ? cap_call.size() : exp_call.size();
    n_i = 0; n_w = 0; n_p = 0;
    for (int i = 0; i < m; i++) begin
      chk("call_kind", cap_call[i], exp_call[i]);
      if (exp_call[i] != C_INIT) chk("call_data", cap_data[i], exp_data[i]);
    end
    foreach (cap_call[i]) begin
      if (cap_call[i] == C_INIT) n_i++;
      if (cap_call[i] == C_WIN)  n_w++;
      if (cap_call[i] == C_PIX)  n_p++;
    end
  endtask

  typedef struct {
    logic [1:0]  call;
    logic [31:0] area;
    logic [15:0] color;
    int          n_init;
    int          n_win;
    int          n_pix;
    int          lat;     // -1: latency not checked
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat, ni, nw, np, x0, y0, x1, y1;
    logic [1:0] c;

    tbl[0] = '{2'b10, 32'h00000000, 16'h0000, 1, 0, 0, -1};
    tbl[1] = '{2'b01, 32'h02030404, 16'hF800, 0, 1, 6, -1};
    tbl[2] = '{2'b01, 32'h05000400, 16'h1234, 0, 0, 0, 1};
    tbl[3] = '{2'b11, 32'h00000909, 16'h07E0, 1, 0, 0, -1};
    tbl[4] = '{2'b01, 32'h07070707, 16'h001F, 0, 1, 1, -1};
    tbl[5] = '{2'b01, 32'hFAFCFFFF, 16'hABCD, 0, 1, 24, -1};
    tbl[6] = '{2'b01, 32'hFFFFFFFF, 16'h5555, 0, 1, 1, -1};
    tbl[7] = '{2'b01, 32'h00050004, 16'hFFFF, 0, 0, 0, 1};
    tbl[8] = '{2'b01, 32'h00000301, 16'h8001, 0, 1, 8, -1};

    RESET = 1'b0;
    repeat (3) @(negedge CLOCK);
    chk("rst_call", oCall, 0);
    chk("rst_data", oData, 0);
    chk("rst_done", oDone, 0);
    chk("rst_busy", oBusy, 0);
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK);

    for (int k = 0; k < 9; k++) begin
      run_req(tbl[k].call, tbl[k].area, tbl[k].color, lat, ni, nw, np);
      chk($sformatf("tbl%0d_init", k), ni, tbl[k].n_init);
      chk($sformatf("tbl%0d_win", k), nw, tbl[k].n_win);
      chk($sformatf("tbl%0d_pix", k), np, tbl[k].n_pix);
      if (tbl[k].lat >= 0) chk($sformatf("tbl%0d_latency", k), lat, tbl[k].lat);
    end

    // Held request is taken again only after the DONE cycle
    @(negedge CLOCK);
    cap_call.delete(); cap_data.delete(); done_cnt = 0;
    iCall = 2'b10;
    lat = 0;
    do begin @(negedge CLOCK); lat++; end while (!oDone && lat < 100);
    chk("hold_first_done", oDone, 1);
    @(negedge CLOCK);
    chk("hold_done_one_cycle", oDone, 0);
    lat = 0;
    do begin @(negedge CLOCK); lat++; end while (!oDone && lat < 100);
    chk("hold_second_done", oDone, 1);
    iCall = 2'b00;
    repeat (3) @(negedge CLOCK);
    chk("hold_two_inits", cap_call.size(), 2);
    chk("hold_done_cnt", done_cnt, 2);

    // Asynchronous reset in the middle of a 10x10 fill
    @(negedge CLOCK);
    cap_call.delete(); cap_data.delete(); done_cnt = 0;
    iCall = 2'b01; iArea = 32'h00000909; iColor = 16'h0F0F;
    repeat (20) @(negedge CLOCK);
    chk("mid_fill_busy", oBusy, 1);
    chk("mid_fill_progress", cap_call.size() > 1, 1);
    #2 RESET = 1'b0;
    #1;
    chk("async_rst_call", oCall, 0);
    chk("async_rst_data", oData, 0);
    chk("async_rst_done", oDone, 0);
    chk("async_rst_busy", oBusy, 0);
    iCall = 2'b00;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    chk("no_done_after_rst", done_cnt, 0);
    chk("idle_after_rst", oCall, 0);

    // Random requests, small rectangles anywhere in the 256x256 space
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 9) == 0)      c = 2'b10;
      else if ($urandom_range(0, 9) == 0) c = 2'b11;
      else                                c = 2'b01;
      x0 = $urandom_range(0, 255);
      y0 = $urandom_range(0, 255);
      x1 = x0 + $urandom_range(0, 5); if (x1 > 255) x1 = 255;
      y1 = y0 + $urandom_range(0, 4); if (y1 > 255) y1 = 255;
      if ($urandom_range(0, 7) == 0 && x0 > 0) x1 = x0 - 1;
      if ($urandom_range(0, 7) == 0 && y0 > 0) y1 = y0 - 1;
      run_req(c, {x0[7:0], y0[7:0], x1[7:0], y1[7:0]}, 16'($urandom), lat, ni, nw, np);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
